fc_seq_ctrl: RTL
================

# fc_seq_ctrl

Sequencer and accumulator for the three-neuron fully-connected layer. It drives the `count_ful`/`count_finish` index pair into the FC weight ROM, which returns three signed 16-bit weights combinationally. It consumes the flattened 480-element feature stream and multiply-accumulates each feature against the three weights. It then presents three saturated fixed-point results to the classifier stage.

## Interface
Parameters:
- `N_INNER`, 30: features per group; range of `count_ful` (≤31).
- `N_OUTER`, 16: groups per inference; range of `count_finish` (≤31).
- `FRAC_BITS`, 8: right-shift applied to accumulators before saturation.
- `ACC_W`, 40: accumulator width.

Ports:
- `clk`, input, 1: single clock.
- `rst_n`, input, 1: synchronous, active-low reset.
- `start`, input, 1: begin inference; accepted only in IDLE.
- `feat_data`, input, 16: signed feature.
- `feat_valid`, input, 1: feature-stream valid.
- `feat_ready`, output, 1: feature-stream ready.
- `count_ful`, output, 5: inner index to the ROM; 0 = idle (ROM outputs zeros).
- `count_finish`, output, 5: outer index to the ROM.
- `weight_in[3:1]`, input, 3×16 signed: ROM weights for the current indices.
- `res_data[3:1]`, output, 3×16 signed: results.
- `res_valid`, output, 1: results valid.
- `res_ready`, input, 1: consumer accepts results.
- `busy`, output, 1: high in RUN or DONE.

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → DONE after the last beat is accepted.
  - DONE → IDLE on `res_valid && res_ready`.
- Start acceptance:
  - On `start` in IDLE: clear all three accumulators, set `count_ful=1`, `count_finish=1`.
  - `start` in RUN or DONE is ignored.
- `feat_ready` = (state == RUN).
- A beat is the cycle where `feat_valid && feat_ready`.
- On each beat, for k = 1..3: `acc[k] += feat_data * weight_in[k]`.
  - The product is a 32-bit signed value, sign-extended to `ACC_W`.
  - Accumulation wraps mod 2^ACC_W; no overflow detection.
- Index advance on each beat:
  - If `count_ful < N_INNER`, increment `count_ful`.
  - Otherwise set `count_ful=1` and increment `count_finish`.
  - The beat with `count_ful==N_INNER && count_finish==N_OUTER` is the last beat. It moves to DONE, with `count_ful=0` and `count_finish=0`.
- No beat (`feat_valid=0`): indices and accumulators hold.
- Result (computed combinationally from the registered accumulators): `res_data[k] = sat16(acc[k] >>> FRAC_BITS)`.
  - Arithmetic shift.
  - Clamp to [-32768, 32767].
- `res_valid` = (state == DONE).
- `res_data` is stable while `res_valid` is high and not yet accepted.
- Outside RUN, `count_ful=0` and `count_finish=0`.

## Timing
- Reset values:
  - state = IDLE.
  - `count_ful=0`, `count_finish=0`.
  - `feat_ready=0`, `res_valid=0`, `busy=0`.
  - accumulators = 0, so `res_data` = 0.
- `start` sampled at edge t: `feat_ready=1` and `count_ful=1` from t+1.
- The ROM is combinational. The weight for the current index is valid in the same cycle, and the product is used in the beat cycle.
- Throughput is one feature per cycle. With a continuous stream, the minimum latency from `start` to `res_valid` is 1 + 480 cycles.
- `res_valid` rises the cycle after the last beat.
- `res_ready` held high in DONE: IDLE on the next cycle.
- `start` in the same cycle as the DONE handshake is ignored. `start` must be reasserted in IDLE.
- `rst_n` low mid-RUN or mid-DONE: all state returns to reset values at the next edge. Partial sums are discarded.

## Configuration
- `FC_RELU_EN` defined: `res_data[k] = max(0, sat16(...))`; negative results are output as 0.
- `FC_RELU_EN` undefined: signed saturated result passed through unchanged.

## Structure
- Shared package `fc_pkg` holds:
  - the state enum `fc_state_t` (IDLE, RUN, DONE);
  - the constants `FC_N_OUT=3`, `FC_N_INNER=30`, `FC_N_OUTER=16`, `FC_FEAT_W=16`;
  - the function `sat16`.
- One sub-module, `fc_mac_lane`: a single accumulator with clear, enable, multiply, shift/saturate and optional ReLU. It is instantiated three times.
- The FSM and index counters live in the top level.

## Test plan
- Reset, then a continuous stream of 480 features all equal to 256, with all weights = 256 (FRAC_BITS=8):
  - `res_valid` rises at cycle 481 after `start`.
  - Each result = sat16(480·65536 >>> 8) = 32767.
- Stream with `feat_valid` toggling every other cycle:
  - Indices advance only on beats.
  - `count_ful` wraps 30→1 while `count_finish` increments 1→2.
  - Completion occurs after 480 beats.
- Single nonzero feature 512 at index (f=3, c=7) with weights [3]=−2, [2]=1, [1]=4:
  - Results = −4, 2, 8 without `FC_RELU_EN`.
  - Results = 0, 2, 8 with it.
- DONE held with `res_ready=0` for 10 cycles while `start` is pulsed:
  - `res_data` stays stable and `start` is ignored.
  - After `res_ready`, the block returns to IDLE.
- `rst_n` asserted after 200 beats:
  - Next cycle: IDLE, counts 0, `feat_ready=0`, results 0.
  - A new run produces correct results with no residue from the aborted run.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types, constants and the saturation helper for the FC layer sequencer.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fc_state_t;

  localparam int FC_N_OUT   = 3;
  localparam int FC_N_INNER = 30;
  localparam int FC_N_OUTER = 16;
  localparam int FC_FEAT_W  = 16;

  // Clamp a sign-extended value into the signed 16-bit range.
  function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
    logic signed [15:0] r;
    if (v > 64'sd32767) begin
      r = 16'sh7fff;
    end else if (v < -64'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One accumulator lane: clear, multiply-accumulate, shift/saturate.
// Optional ReLU on the output when FC_RELU_EN is defined.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int ACC_W     = 40,
  parameter int FRAC_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [FC_FEAT_W-1:0] feat,
  input  logic signed [FC_FEAT_W-1:0] weight,
  output logic signed [15:0]          res
);

  logic signed [31:0]      prod_s;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] shifted_s;
  logic signed [63:0]      wide_s;
  logic signed [15:0]      sat_s;

  assign prod_s = feat * weight;

  // Accumulator register; the sum wraps at ACC_W bits by design.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + {{(ACC_W-32){prod_s[31]}}, prod_s};
    end else begin
      acc_r <= acc_r;
    end
  end

  assign shifted_s = acc_r >>> FRAC_BITS;
  assign wide_s    = {{(64-ACC_W){shifted_s[ACC_W-1]}}, shifted_s};
  assign sat_s     = sat16(wide_s);

  // Output stage: optional rectification of the saturated result.
  always_comb begin
    res = sat_s;
`ifdef FC_RELU_EN
    if (sat_s[15]) begin
      res = 16'sd0;
    end else begin
      res = sat_s;
    end
`endif
  end

endmodule

// File: rtl/fc_seq_ctrl.sv
// FC layer sequencer: walks the ROM indices over the feature stream and
// accumulates three lanes. Optional ReLU output via FC_RELU_EN.
module fc_seq_ctrl
  import fc_pkg::*;
#(
  parameter int N_INNER   = FC_N_INNER,
  parameter int N_OUTER   = FC_N_OUTER,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [15:0] feat_data,
  input  logic               feat_valid,
  output logic               feat_ready,
  output logic [4:0]         count_ful,
  output logic [4:0]         count_finish,
  input  logic signed [15:0] weight_in [3:1],
  output logic signed [15:0] res_data [3:1],
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy
);

  localparam logic [4:0] N_INNER_L = 5'(N_INNER);
  localparam logic [4:0] N_OUTER_L = 5'(N_OUTER);

  fc_state_t  state_r, state_s;
  logic [4:0] count_ful_r, count_ful_s;
  logic [4:0] count_finish_r, count_finish_s;
  logic       feat_ready_r, res_valid_r, busy_r;
  logic       beat_s, clr_s;

  assign beat_s = feat_valid && (state_r == RUN);

  // Next-state and index advance.
  always_comb begin
    state_s        = state_r;
    count_ful_s    = count_ful_r;
    count_finish_s = count_finish_r;
    clr_s          = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s        = RUN;
          count_ful_s    = 5'd1;
          count_finish_s = 5'd1;
          clr_s          = 1'b1;
        end else begin
          count_ful_s    = 5'd0;
          count_finish_s = 5'd0;
        end
      end
      RUN: begin
        if (!beat_s) begin
          state_s = RUN;
        end else if (count_ful_r < N_INNER_L) begin
          count_ful_s = count_ful_r + 5'd1;
        end else if (count_finish_r == N_OUTER_L) begin
          state_s        = DONE;
          count_ful_s    = 5'd0;
          count_finish_s = 5'd0;
        end else begin
          count_ful_s    = 5'd1;
          count_finish_s = count_finish_r + 5'd1;
        end
      end
      DONE: begin
        count_ful_s    = 5'd0;
        count_finish_s = 5'd0;
        if (res_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s        = IDLE;
        count_ful_s    = 5'd0;
        count_finish_s = 5'd0;
      end
    endcase
  end

  // State, index and status flags; flags are decoded from the next state
  // so they line up with the registered state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      count_ful_r    <= 5'd0;
      count_finish_r <= 5'd0;
      feat_ready_r   <= 1'b0;
      res_valid_r    <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      count_ful_r    <= count_ful_s;
      count_finish_r <= count_finish_s;
      feat_ready_r   <= (state_s == RUN);
      res_valid_r    <= (state_s == DONE);
      busy_r         <= (state_s != IDLE);
    end
  end

  assign feat_ready   = feat_ready_r;
  assign res_valid    = res_valid_r;
  assign busy         = busy_r;
  assign count_ful    = count_ful_r;
  assign count_finish = count_finish_r;

  for (genvar k = 1; k <= FC_N_OUT; k++) begin : g_lane
    fc_mac_lane #(
      .ACC_W     (ACC_W),
      .FRAC_BITS (FRAC_BITS)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr_s),
      .en     (beat_s),
      .feat   (feat_data),
      .weight (weight_in[k]),
      .res    (res_data[k])
    );
  end

endmodule
